// File: rtl/ps2_digit_display.sv
// Keypad digit entry buffer with a multiplexed 4-position
// seven-segment scanner (active-low segments and anodes).
module ps2_digit_display #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] digit_i,
  input  logic       digit_stb_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic [2:0] count_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic [PW-1:0] pre_q;
  logic [1:0]    pos_q;
  logic          wrap;
  logic          is_num;
  logic          is_bs;
  logic          is_clr;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    is_num = (digit_i <= 4'd9);
    is_bs  = (digit_i == 4'hE);
    is_clr = (digit_i == 4'hF);
  end

  // Codes 0xA..0xD fall through to default and leave state alone.
  always_comb begin
    dig_d = dig_q;
    cnt_d = cnt_q;
    if (digit_stb_i) begin
      unique case (1'b1)
        is_num: begin
          dig_d[3] = dig_q[2];
          dig_d[2] = dig_q[1];
          dig_d[1] = dig_q[0];
          dig_d[0] = digit_i;
          if (cnt_q != 3'd4)
            cnt_d = cnt_q + 3'd1;
        end
        is_bs: begin
          if (cnt_q != 3'd0) begin
            dig_d[0] = dig_q[1];
            dig_d[1] = dig_q[2];
            dig_d[2] = dig_q[3];
            dig_d[3] = 4'd0;
            cnt_d    = cnt_q - 3'd1;
          end
        end
        is_clr: begin
          for (int i = 0; i < 4; i++)
            dig_d[i] = 4'd0;
          cnt_d = 3'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wrap  = (pre_q == PMAX);
    an_d  = ~(4'b0001 << pos_q);
    seg_d = ({1'b0, pos_q} < cnt_q)
          ? enc(dig_q[pos_q]) : 7'h7F;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++)
        dig_q[i] <= 4'd0;
      cnt_q <= 3'd0;
      pre_q <= '0;
      pos_q <= 2'd0;
      seg_o <= 7'h7F;
      an_o  <= 4'b1111;
    end else begin
      dig_q <= dig_d;
      cnt_q <= cnt_d;
      pre_q <= wrap ? '0 : pre_q + 1'b1;
      if (wrap)
        pos_q <= pos_q + 2'd1;
      seg_o <= seg_d;
      an_o  <= an_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: tb/tb_ps2_digit_display.sv
// Scoreboard bench: a queue-based model predicts each cycle's
// outputs; a negedge monitor pops and compares.
module tb_ps2_digit_display;

  localparam int SD = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] digit_i;
  logic       digit_stb_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic [2:0] count_o;

  exp_t sbq[$];
  int   q[$];
  int   ticks;
  int   checks;
  int   passes;

  logic [6:0] enc_tab [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  ps2_digit_display #(.SCAN_DIV(SD)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .digit_i     (digit_i),
    .digit_stb_i (digit_stb_i),
    .seg_o       (seg_o),
    .an_o        (an_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %h expected %h",
                  name, $time, act, exp);
  endtask

  // Model: q holds digits newest-first; scan position is
  // derived from cycles elapsed since the last reset edge.
  task automatic step(input logic r, input logic s,
                      input logic [3:0] d);
    exp_t e;
    int p;
    rst_i = r;
    digit_stb_i = s;
    digit_i = d;
    if (!r) begin
      e = '{seg: 7'h7F, an: 4'hF, cnt: 3'd0};
      q.delete();
      ticks = 0;
    end else begin
      p = (ticks / SD) % 4;
      e.an = ~(4'b0001 << p);
      e.seg = (p < q.size()) ? enc_tab[q[p]] : 7'h7F;
      if (s) begin
        if (d <= 4'd9) begin
          q.push_front(int'(d));
          if (q.size() > 4) void'(q.pop_back());
        end else if (d == 4'hE) begin
          if (q.size() > 0) void'(q.pop_front());
        end else if (d == 4'hF) begin
          q.delete();
        end
      end
      e.cnt = 3'(q.size());
      ticks++;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("seg_o", {1'b0, seg_o}, {1'b0, e.seg});
      check("an_o", {4'b0, an_o}, {4'b0, e.an});
      check("count_o", {5'b0, count_o}, {5'b0, e.cnt});
    end
  end

  initial begin
    logic r;
    logic s;
    logic [3:0] d;
    checks = 0;
    passes = 0;
    ticks = 0;
    step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    repeat (20) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 4'd7);
    repeat (16) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hF);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 4'(i));
    repeat (16) step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'hE);
      step(1'b1, 1'b0, 4'd0);
    end
    repeat (16) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hB);
    step(1'b1, 1'b1, 4'hA);
    step(1'b1, 1'b1, 4'd8);
    step(1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 4'hB);
    step(1'b1, 1'b1, 4'hA);
    repeat (16) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'hF);
    repeat (16) step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd2);
    step(1'b1, 1'b1, 4'd4);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd9);
    repeat (8) step(1'b1, 1'b0, 4'd0);
    repeat (3000) begin
      r = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        d = 4'($urandom_range(10, 15));
      else
        d = 4'($urandom_range(0, 9));
      step(r, s, d);
    end
    rst_i = 1'b1;
    digit_stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_digit_display.md
PS2_DIGIT_DISPLAY -- requirements
Module: ps2_digit_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit position is driven (legal range 2..65535).
REQ-002 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port digit_i  input  4  key code from the PS/2 receiver stage.
REQ-005 SHALL have port digit_stb_i  input  1  one-cycle strobe; digit_i is valid in that cycle.
REQ-006 SHALL have port seg_o  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port an_o  output  4  digit-position enable, active-low one-hot, bit 0 is the rightmost position.
REQ-008 SHALL have port count_o  output  3  number of digits held (0..4).

Function
REQ-009 SHALL hold a 4-entry digit buffer buf[0..3] (buf[0] rightmost/newest) and a count register; all are registers.
REQ-010 On digit_stb_i=1 with digit_i 0..9: buf[3..1] <= buf[2..0], buf[0] <= digit_i, count <= min(count+1, 4); when count=4, the oldest digit is discarded.
REQ-011 On digit_stb_i=1 with digit_i=0xE (backspace): buf[0..2] <= buf[1..3], buf[3] <= 0, count <= count-1; when count=0, no state changes.
REQ-012 On digit_stb_i=1 with digit_i=0xF (clear): all buf entries <= 0 and count <= 0.
REQ-013 On digit_stb_i=1 with digit_i 0xA..0xD: no state changes.
REQ-014 When digit_stb_i=0: buffer and count hold; digit_i is ignored.
REQ-015 Buffer/count update SHALL take effect at the rising edge that samples the strobe; count_o SHALL equal the count register (zero added latency).
REQ-016 SHALL contain a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; the 2-bit position pos SHALL increment (3 wraps to 0) on the edge where the prescaler wraps.
REQ-017 seg_o and an_o SHALL be registered every cycle from the pre-edge values of pos, buf and count (one-cycle latency).
REQ-018 an_o SHALL be ~(4'b0001 << pos).
REQ-019 If pos < count, seg_o SHALL be the encoding of buf[pos]; otherwise seg_o = 7'h7F (position blanked, leading positions blank).
REQ-020 Encoding (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-021 A strobe arriving in the same cycle as a prescaler wrap SHALL update both the buffer and pos at that edge; the next registered output SHALL use the old buffer and the old pos.

Reset
REQ-022 When rst_i=0 at a rising edge: buf all 0, count 0, prescaler 0, pos 0, seg_o = 7'h7F, an_o = 4'b1111, count_o = 0.
REQ-023 A strobe sampled while rst_i=0 SHALL be ignored; reset SHALL take priority over every update.
REQ-024 Reset asserted mid-scan or mid-entry SHALL clear all state at that edge; after rst_i returns to 1, the first registered output SHALL be an_o = 4'b1110 with seg_o = 7'h7F.

Verification
REQ-025 Reset, no strobes, SCAN_DIV=4 -> an_o cycles 1110,1101,1011,0111 with 4 cycles each, wrapping; seg_o constantly 7F; count_o=0.
REQ-026 Strobe 3, then 7 -> count_o=2; pos0 shows 78 (7), pos1 shows 30 (3), pos2/pos3 show 7F.
REQ-027 Strobe 1,2,3,4,5 -> count_o stays 4 after the 4th strobe; positions 3..0 show 2,3,4,5 (24,30,19,12); the digit 1 is discarded.
REQ-028 From 4 digits, strobe E twice, then strobe E three more times -> count_o 3, 2, 1, 0, 0; no underflow; all positions show 7F at count 0.
REQ-029 Strobes 0xB and 0xA -> no change to count_o or seg_o; strobe F after 3 digits -> count_o=0 at the next edge and all positions blank.
REQ-030 rst_i=0 for one cycle during a strobe while count=2 -> count_o=0, an_o=1111, seg_o=7F at that edge; the strobed digit is not stored.
